// File: rtl/target_sequencer_if.sv
// Target hand-off channel between the sequencer and the PWM core.
// The sequencer is the master: it offers tgt_data under tgt_valid, the core answers with tgt_ready.
interface target_sequencer_if;
   logic        tgt_valid;
   logic        tgt_ready;
   logic [31:0] tgt_data;

   modport master (output tgt_valid, output tgt_data, input tgt_ready);
   modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/target_sequencer.sv
// Debounces the user switches, builds the PWM target from them and hands each new
// target to the PWM core, offering it only on a PWM period boundary.
module target_sequencer #(
   parameter int          DEBOUNCE_CYCLES = 50000,
   parameter logic [31:0] RESET_TARGET    = 32'h4995CDD1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [9:0]                 sw_i,
   input  logic                       period_end_i,
   target_sequencer_if.master         tgt,
   output logic [31:0]                target_o,
   output logic                       clk_sel_o,
   output logic                       disp_sel_o,
   output logic                       busy_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT_BND, OFFER} state_t;

   state_t      state_q, state_d;
   logic [9:0]  sw_m_q, sw_s_q, sw_p_q, stable_q;
   logic [CW-1:0] cnt_q;
   logic        upd_q, clk_sel_q, disp_sel_q, seen_q, seen_d;
   logic [31:0] pending_q, tgt_data_q, target_q;
   logic [31:0] cand;
   logic [7:0]  v;
   logic        deb_load, change, handshake;
   logic        ld_pend, ld_data, data_from_cand, commit;

   // A switch word is taken only after it has held unchanged for the full window.
   assign deb_load = (sw_s_q != stable_q) && (sw_s_q == sw_p_q) && (cnt_q == CNT_LAST);

   always_comb begin
      v    = {stable_q[5:0], 2'b00};
      cand = RESET_TARGET;
      case (stable_q[7:6])
         2'd1:    cand[23:16] = v;
         2'd2:    cand[15:8]  = v;
         2'd3:    cand[31:24] = v;
         default: cand        = RESET_TARGET;
      endcase
   end

   // upd_q marks the first cycle the new stable value is visible to the candidate logic.
   assign change    = upd_q && (cand != pending_q);
   assign handshake = tgt.tgt_valid && tgt.tgt_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (change) state_d = WAIT_BND;
         WAIT_BND: if (period_end_i) state_d = OFFER;
         OFFER:    if (handshake) state_d = (seen_q || change) ? WAIT_BND : IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      tgt.tgt_valid  = (state_q == OFFER);
      busy_o         = (state_q != IDLE);
      ld_pend        = change;
      ld_data        = (state_q == WAIT_BND) && period_end_i;
      data_from_cand = change;
      commit         = (state_q == OFFER) && handshake;
      seen_d         = 1'b0;
      if (state_q == OFFER && !handshake) seen_d = seen_q || change;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_m_q     <= '0;
         sw_s_q     <= '0;
         sw_p_q     <= '0;
         stable_q   <= '0;
         cnt_q      <= '0;
         upd_q      <= 1'b0;
         clk_sel_q  <= 1'b0;
         disp_sel_q <= 1'b0;
         seen_q     <= 1'b0;
         pending_q  <= RESET_TARGET;
         tgt_data_q <= RESET_TARGET;
         target_q   <= RESET_TARGET;
      end else begin
         sw_m_q <= sw_i;
         sw_s_q <= sw_m_q;
         sw_p_q <= sw_s_q;
         if (sw_s_q == stable_q || sw_s_q != sw_p_q || deb_load) cnt_q <= '0;
         else                                                   cnt_q <= cnt_q + 1'b1;
         if (deb_load) stable_q <= sw_s_q;
         upd_q      <= deb_load && (sw_s_q[7:0] != stable_q[7:0]);
         clk_sel_q  <= stable_q[8];
         disp_sel_q <= stable_q[9];
         seen_q     <= seen_d;
         if (ld_pend) pending_q  <= cand;
         if (ld_data) tgt_data_q <= data_from_cand ? cand : pending_q;
         if (commit)  target_q   <= tgt_data_q;
      end
   end

   assign tgt.tgt_data = tgt_data_q;
   assign target_o     = target_q;
   assign clk_sel_o    = clk_sel_q;
   assign disp_sel_o   = disp_sel_q;
endmodule

// File: tb/tb_target_sequencer.sv
// Directed bench for target_sequencer: a vector table for the steady-state
// hand-offs plus hand-written sequences for bounce, merging, stall and reset.
module tb_target_sequencer;
   localparam int DEB = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] sw  = '0;
   logic       period_end = 1'b0;
   logic [31:0] target;
   logic       clk_sel, disp_sel, busy;
   int         total = 0;
   int         bad   = 0;

   target_sequencer_if tif ();

   target_sequencer #(.DEBOUNCE_CYCLES(DEB), .RESET_TARGET(32'h4995CDD1)) dut (
      .clk(clk), .rst(rst), .sw_i(sw), .period_end_i(period_end), .tgt(tif),
      .target_o(target), .clk_sel_o(clk_sel), .disp_sel_o(disp_sel), .busy_o(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  sw;
      logic        offer;
      logic [31:0] data;
      logic        csel;
      logic        dsel;
   } vec_t;

   vec_t vecs[7];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic pulse_bnd();
      period_end = 1'b1;
      step(1);
      period_end = 1'b0;
   endtask

   task automatic accept();
      tif.tgt_ready = 1'b1;
      step(1);
      tif.tgt_ready = 1'b0;
   endtask

   // Settle a switch word, then run one full boundary + hand-off expecting data.
   task automatic settle_and_commit(input logic [9:0] s, input logic [31:0] data);
      sw = s;
      step(DEB + 8);
      chk("busy_pending", {31'd0, busy}, 32'd1);
      pulse_bnd();
      chk("offer_valid", {31'd0, tif.tgt_valid}, 32'd1);
      chk("offer_data", tif.tgt_data, data);
      accept();
      chk("commit_target", target, data);
      chk("idle_after", {30'd0, busy, tif.tgt_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] exp_tgt;
      int errs;
      vecs[0] = '{10'b00_01_111111, 1'b1, 32'h49FCCDD1, 1'b0, 1'b0};
      vecs[1] = '{10'b11_01_111111, 1'b0, 32'h49FCCDD1, 1'b1, 1'b1};
      vecs[2] = '{10'b01_10_000001, 1'b1, 32'h499504D1, 1'b1, 1'b0};
      vecs[3] = '{10'b00_00_101010, 1'b1, 32'h4995CDD1, 1'b0, 1'b0};
      vecs[4] = '{10'b00_00_111111, 1'b0, 32'h4995CDD1, 1'b0, 1'b0};
      vecs[5] = '{10'b00_11_000001, 1'b1, 32'h0495CDD1, 1'b0, 1'b0};
      vecs[6] = '{10'b10_00_000000, 1'b1, 32'h4995CDD1, 1'b0, 1'b1};

      tif.tgt_ready = 1'b0;
      step(3);
      rst = 1'b0;
      step(2);
      chk("rst_target", target, 32'h4995CDD1);
      chk("rst_data", tif.tgt_data, 32'h4995CDD1);
      chk("rst_flags", {28'd0, tif.tgt_valid, busy, clk_sel, disp_sel}, 32'd0);

      exp_tgt = 32'h4995CDD1;
      for (int i = 0; i < 7; i++) begin
         sw = vecs[i].sw;
         step(DEB + 8);
         chk($sformatf("v%0d_sel", i), {30'd0, clk_sel, disp_sel}, {30'd0, vecs[i].csel, vecs[i].dsel});
         chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].offer});
         if (vecs[i].offer) begin
            pulse_bnd();
            chk($sformatf("v%0d_valid", i), {31'd0, tif.tgt_valid}, 32'd1);
            chk($sformatf("v%0d_data", i), tif.tgt_data, vecs[i].data);
            accept();
            chk($sformatf("v%0d_idle", i), {30'd0, busy, tif.tgt_valid}, 32'd0);
         end
         chk($sformatf("v%0d_target", i), target, vecs[i].data);
      end

      // Bounce sw[0] every 10 clk; nothing may change until the last edge has held.
      settle_and_commit(10'b00_01_000000, 32'h4900CDD1);
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         sw[0] = ~sw[0];
         for (int k = 0; k < 10; k++) begin
            step(1);
            if (busy) errs++;
         end
      end
      chk("bounce_quiet", errs, 0);
      sw[0] = 1'b1;
      step(DEB + 3);
      chk("deb_not_yet", {31'd0, busy}, 32'd0);
      step(1);
      chk("deb_latency", {31'd0, busy}, 32'd1);
      pulse_bnd();
      chk("bounce_data", tif.tgt_data, 32'h4904CDD1);
      accept();
      chk("bounce_target", target, 32'h4904CDD1);

      // Two changes while waiting for the boundary collapse into one offer.
      sw = 10'b00_10_000001;
      step(DEB + 8);
      chk("merge_busy", {31'd0, busy}, 32'd1);
      sw = 10'b00_11_100000;
      step(DEB + 8);
      chk("merge_no_offer_yet", {31'd0, tif.tgt_valid}, 32'd0);
      pulse_bnd();
      chk("merge_data", tif.tgt_data, 32'h8095CDD1);
      accept();
      chk("merge_target", target, 32'h8095CDD1);
      pulse_bnd();
      pulse_bnd();
      chk("merge_single", {30'd0, busy, tif.tgt_valid}, 32'd0);

      // Stalled offer: data holds while a new target arrives behind it.
      sw = 10'b00_10_000010;
      step(DEB + 8);
      pulse_bnd();
      sw = 10'b00_01_000100;
      errs = 0;
      for (int i = 0; i < DEB + 8; i++) begin
         period_end = (i == 5 || i == DEB + 6);
         step(1);
         if (tif.tgt_data !== 32'h499508D1 || tif.tgt_valid !== 1'b1) errs++;
      end
      period_end = 1'b0;
      chk("stall_hold", errs, 0);
      accept();
      chk("stall_target", target, 32'h499508D1);
      chk("stall_rewait", {30'd0, busy, tif.tgt_valid}, 32'd2);
      step(3);
      chk("stall_wait_bnd", {31'd0, tif.tgt_valid}, 32'd0);
      pulse_bnd();
      chk("second_data", tif.tgt_data, 32'h4910CDD1);
      accept();
      chk("second_target", target, 32'h4910CDD1);

      // Reset during an offer drops valid at once and never commits.
      sw = 10'b00_01_001000;
      step(DEB + 8);
      pulse_bnd();
      chk("pre_rst_valid", {31'd0, tif.tgt_valid}, 32'd1);
      chk("pre_rst_data", tif.tgt_data, 32'h4920CDD1);
      tif.tgt_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_drop_valid", {30'd0, tif.tgt_valid, busy}, 32'd0);
      chk("rst_target_back", target, 32'h4995CDD1);
      step(1);
      rst = 1'b0;
      step(2);
      chk("rst_sel", {30'd0, clk_sel, disp_sel}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
